// File: rtl/sprite_rom_arb_pkg.sv
// sprite_rom_arb_pkg: shared tag type and default widths for the sprite ROM arbiter
package sprite_rom_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_AUX0,
        TAG_AUX1
    } tag_t;

    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_DATA_W     = 2;
    localparam int DEF_STARVE_LIM = 255;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: display, auxiliary and ROM-side signals of the sprite ROM arbiter
interface sprite_rom_arbiter_if
    import sprite_rom_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic                  disp_req;
    logic [ADDR_W-1:0]     disp_addr;
    logic                  disp_valid;
    logic [DATA_W-1:0]     disp_data;
    logic [1:0]            aux_req;
    logic [2*ADDR_W-1:0]   aux_addr;
    logic [1:0]            aux_gnt;
    logic [1:0]            aux_valid;
    logic [DATA_W-1:0]     aux_data;
    logic [1:0]            aux_starve;
    logic [ADDR_W-1:0]     rom_address;
    logic [DATA_W-1:0]     rom_q;

    modport master (
        output disp_req, disp_addr, aux_req, aux_addr, rom_q,
        input  disp_valid, disp_data, aux_gnt, aux_valid, aux_data, aux_starve, rom_address
    );

    modport slave (
        input  disp_req, disp_addr, aux_req, aux_addr, rom_q,
        output disp_valid, disp_data, aux_gnt, aux_valid, aux_data, aux_starve, rom_address
    );

endinterface

// File: rtl/sprite_rom_arb_rr.sv
// sprite_rom_arb_rr: two-way round-robin picker; ptr selects the winner only on contention
module sprite_rom_arb_rr (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt = &req ? (ptr ? 2'b10 : 2'b01) : req;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one sprite ROM port between display fetch and two auxiliary readers
module sprite_rom_arbiter
    import sprite_rom_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input logic vga_clk,
    input logic reset_n,
    sprite_rom_arbiter_if.slave bus
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic              ptr;
    logic [1:0]        rr_gnt;
    logic [7:0]        cnt [2];
    logic [7:0]        cnt_nxt [2];
    logic [DATA_W-1:0] q;
    tag_t              tag_pipe [ROM_LAT];
    tag_t              win;
    tag_t              ret;

    sprite_rom_arb_rr u_rr (.req(bus.aux_req), .ptr(ptr), .gnt(rr_gnt));

    assign bus.aux_gnt = (reset_n && !bus.disp_req) ? rr_gnt : 2'b00;
    assign q = bus.rom_q;
    assign ret = tag_pipe[ROM_LAT-1];

    always_comb begin
        win = bus.disp_req ? TAG_DISP : bus.aux_gnt[0] ? TAG_AUX0 : bus.aux_gnt[1] ? TAG_AUX1 : TAG_NONE;
        for (int j = 0; j < 2; j++)
            cnt_nxt[j] = (!bus.aux_req[j] || bus.aux_gnt[j]) ? 8'd0 : (cnt[j] == LIM) ? cnt[j] : cnt[j] + 8'd1;
    end

    // the tag travels alongside the ROM access so each return lands on the right requester
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            ptr             <= 1'b0;
            bus.rom_address <= '0;
            bus.disp_valid  <= 1'b0;
            bus.disp_data   <= '0;
            bus.aux_valid   <= 2'b00;
            bus.aux_data    <= '0;
            bus.aux_starve  <= 2'b00;
            for (int j = 0; j < 2; j++) cnt[j] <= 8'd0;
            for (int j = 0; j < ROM_LAT; j++) tag_pipe[j] <= TAG_NONE;
        end else begin
            ptr             <= |bus.aux_gnt ? bus.aux_gnt[0] : ptr;
            bus.rom_address <= win == TAG_DISP ? bus.disp_addr :
                               win == TAG_AUX0 ? bus.aux_addr[ADDR_W-1:0] :
                               win == TAG_AUX1 ? bus.aux_addr[2*ADDR_W-1:ADDR_W] : bus.rom_address;
            tag_pipe[0]     <= win;
            for (int j = 1; j < ROM_LAT; j++) tag_pipe[j] <= tag_pipe[j-1];
            bus.disp_valid  <= ret == TAG_DISP;
            bus.disp_data   <= ret == TAG_DISP ? q : bus.disp_data;
            bus.aux_valid   <= {ret == TAG_AUX1, ret == TAG_AUX0};
            bus.aux_data    <= (ret == TAG_AUX0 || ret == TAG_AUX1) ? q : bus.aux_data;
            for (int j = 0; j < 2; j++) cnt[j] <= cnt_nxt[j];
            bus.aux_starve  <= bus.aux_starve | (bus.aux_req & {cnt_nxt[1] == LIM, cnt_nxt[0] == LIM});
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: scoreboard bench driving ROM_LAT=1 and ROM_LAT=3 arbiters in lockstep
module tb_sprite_rom_arbiter;
    import sprite_rom_arb_pkg::*;

    typedef struct {
        tag_t       tag;
        logic [1:0] data;
        int         due;
    } exp_t;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst_at_edge = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb [2][$];
    logic [1:0]  last_d [2];
    logic [1:0]  last_a [2];
    logic [18:0] a3_d1, a3_d2;

    sprite_rom_arbiter_if #(.ADDR_W(19), .DATA_W(2)) b1 ();
    sprite_rom_arbiter_if #(.ADDR_W(19), .DATA_W(2)) b3 ();

    sprite_rom_arbiter #(.ROM_LAT(1)) dut1 (.vga_clk(vga_clk), .reset_n(reset_n), .bus(b1.slave));
    sprite_rom_arbiter #(.ROM_LAT(3)) dut3 (.vga_clk(vga_clk), .reset_n(reset_n), .bus(b3.slave));

    function automatic logic [1:0] rom_fn(input logic [18:0] a);
        return a[1:0] ^ a[3:2] ^ a[9:8];
    endfunction

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !reset_n;
        a3_d1       <= b3.rom_address;
        a3_d2       <= a3_d1;
    end

    assign b1.rom_q = rom_fn(b1.rom_address);
    assign b3.rom_q = rom_fn(a3_d2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input tag_t t, input logic [1:0] d);
        sb[0].push_back('{t, d, cyc + 2});
        sb[1].push_back('{t, d, cyc + 4});
    endtask

    task automatic drive(input logic d, input logic [18:0] da, input logic [1:0] ar, input logic [37:0] aa);
        b1.disp_req = d; b1.disp_addr = da; b1.aux_req = ar; b1.aux_addr = aa;
        b3.disp_req = d; b3.disp_addr = da; b3.aux_req = ar; b3.aux_addr = aa;
    endtask

    // eg is the hand-derived grant for this cycle; accepted reads are queued for the monitor
    task automatic step(input logic d, input logic [18:0] da, input logic [1:0] ar,
                        input logic [37:0] aa, input logic [1:0] eg);
        drive(d, da, ar, aa);
        @(negedge vga_clk);
        chk("aux_gnt_lat1", b1.aux_gnt, eg);
        chk("aux_gnt_lat3", b3.aux_gnt, eg);
        if (d) push(TAG_DISP, rom_fn(da));
        else if (eg[0]) push(TAG_AUX0, rom_fn(aa[18:0]));
        else if (eg[1]) push(TAG_AUX1, rom_fn(aa[37:19]));
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 19'd0, 2'b00, 38'd0, 2'b00);
    endtask

    task automatic mon(input int id, input logic dv, input logic [1:0] dd,
                       input logic [1:0] av, input logic [1:0] ad);
        tag_t obs;
        exp_t e;
        obs = dv ? TAG_DISP : av == 2'b01 ? TAG_AUX0 : av == 2'b10 ? TAG_AUX1 : TAG_NONE;
        if ($countones({dv, av}) > 1) chk($sformatf("valid_onehot%0d", id), {dv, av}, 3'b000);
        if (sb[id].size() > 0 && sb[id][0].due == cyc) begin
            e = sb[id].pop_front();
            chk($sformatf("ret_tag%0d", id), obs, e.tag);
            if (e.tag == TAG_DISP) begin
                chk($sformatf("disp_data%0d", id), dd, e.data);
                last_d[id] = e.data;
            end else begin
                chk($sformatf("aux_data%0d", id), ad, e.data);
                last_a[id] = e.data;
            end
        end else begin
            chk($sformatf("unexpected_valid%0d", id), obs, TAG_NONE);
        end
        if (!dv) chk($sformatf("disp_hold%0d", id), dd, last_d[id]);
        if (av == 2'b00) chk($sformatf("aux_hold%0d", id), ad, last_a[id]);
    endtask

    always @(negedge vga_clk) begin
        if (rst_at_edge) begin
            chk("reset_lat1", {b1.rom_address, b1.disp_valid, b1.disp_data, b1.aux_valid, b1.aux_data, b1.aux_starve}, 64'd0);
            chk("reset_lat3", {b3.rom_address, b3.disp_valid, b3.disp_data, b3.aux_valid, b3.aux_data, b3.aux_starve}, 64'd0);
            sb[0].delete();
            sb[1].delete();
            for (int i = 0; i < 2; i++) begin
                last_d[i] = 2'b00;
                last_a[i] = 2'b00;
            end
        end else if (cyc > 0) begin
            mon(0, b1.disp_valid, b1.disp_data, b1.aux_valid, b1.aux_data);
            mon(1, b3.disp_valid, b3.disp_data, b3.aux_valid, b3.aux_data);
        end
    end

    initial begin
        drive(1'b0, 19'd0, 2'b00, 38'd0);
        repeat (2) @(posedge vga_clk);
        #1 reset_n = 1'b1;
        idle();
        // single display fetch
        step(1'b1, 19'h00100, 2'b00, 38'd0, 2'b00);
        chk("rom_addr_lat1", b1.rom_address, 19'h00100);
        chk("rom_addr_lat3", b3.rom_address, 19'h00100);
        repeat (4) idle();
        // both auxiliaries contend, pointer alternates from aux0
        for (int i = 0; i < 4; i++)
            step(1'b0, 19'd0, 2'b11, {19'h00135, 19'h000a6}, i[0] ? 2'b10 : 2'b01);
        repeat (4) idle();
        // display and aux0 interleaved every cycle
        for (int i = 0; i < 8; i++)
            if (i % 2 == 0) step(1'b1, 19'h00300 + 19'(i), 2'b00, 38'd0, 2'b00);
            else step(1'b0, 19'd0, 2'b01, {19'd0, 19'h00040 + 19'(i)}, 2'b01);
        repeat (4) idle();
        // aux1 withdraws while blocked by display
        repeat (3) step(1'b1, 19'h00200, 2'b10, {19'h00055, 19'd0}, 2'b00);
        chk("wait_cnt_aux1", dut1.cnt[1], 8'd3);
        step(1'b1, 19'h00201, 2'b00, 38'd0, 2'b00);
        chk("wait_cnt_clear", dut1.cnt[1], 8'd0);
        repeat (4) idle();
        // aux0 starved by a long display burst
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 19'h00100 + 19'(i), 2'b01, {19'd0, 19'h00077}, 2'b00);
            if (i == 253) begin
                chk("starve_early_lat1", b1.aux_starve, 2'b00);
                chk("starve_early_lat3", b3.aux_starve, 2'b00);
            end
            if (i == 254) begin
                chk("starve_set_lat1", b1.aux_starve, 2'b01);
                chk("starve_set_lat3", b3.aux_starve, 2'b01);
            end
        end
        step(1'b0, 19'd0, 2'b01, {19'd0, 19'h00077}, 2'b01);
        chk("starve_sticky_lat1", b1.aux_starve, 2'b01);
        chk("starve_sticky_lat3", b3.aux_starve, 2'b01);
        repeat (4) idle();
        // reset with reads in flight
        step(1'b1, 19'h00123, 2'b00, 38'd0, 2'b00);
        step(1'b1, 19'h00456, 2'b00, 38'd0, 2'b00);
        drive(1'b0, 19'd0, 2'b11, {19'h00135, 19'h000a6});
        reset_n = 1'b0;
        @(negedge vga_clk);
        chk("gnt_in_reset_lat1", b1.aux_gnt, 2'b00);
        chk("gnt_in_reset_lat3", b3.aux_gnt, 2'b00);
        @(posedge vga_clk);
        #1 reset_n = 1'b1;
        repeat (3) idle();
        step(1'b0, 19'd0, 2'b11, {19'h00135, 19'h000a6}, 2'b01);
        step(1'b0, 19'd0, 2'b11, {19'h00135, 19'h000a6}, 2'b10);
        repeat (5) idle();
        chk("sb_drained_lat1", sb[0].size(), 0);
        chk("sb_drained_lat3", sb[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, sprite ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 2, ROM palette-index width.
REQ-003 The block SHALL have parameter ROM_LAT, default 1, legal 1..3, cycles from rom_address update to usable rom_q.
REQ-004 The block SHALL have parameter STARVE_LIM, default 255, auxiliary wait-cycle limit, 8-bit.
REQ-005 vga_clk  in  1  the single clock; all state on rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 disp_req  in  1  display pixel-fetch request, high during active video.
REQ-008 disp_addr  in  ADDR_W  display fetch address.
REQ-009 disp_valid  out  1  display read data valid, registered.
REQ-010 disp_data  out  DATA_W  display read data, registered.
REQ-011 aux_req  in  2  auxiliary requesters (aux0 = quiz-text blitter, aux1 = hit-test).
REQ-012 aux_addr  in  2*ADDR_W  packed addresses; aux0 in bits [ADDR_W-1:0].
REQ-013 aux_gnt  out  2  one-hot combinational grant; request accepted at the coming edge.
REQ-014 aux_valid  out  2  one-hot registered read-valid per auxiliary.
REQ-015 aux_data  out  DATA_W  shared auxiliary read data, registered.
REQ-016 aux_starve  out  2  sticky starvation flags.
REQ-017 rom_address  out  ADDR_W  registered address to the ROM.
REQ-018 rom_q  in  DATA_W  ROM read data.

Function
REQ-019 Priority each cycle SHALL be: disp_req first; otherwise round-robin between asserted aux_req bits.
REQ-020 The round-robin pointer SHALL be aux0 after reset, SHALL move to the other auxiliary after each aux grant, and SHALL hold otherwise.
REQ-021 aux_gnt SHALL be zero whenever disp_req is high, and at most one bit SHALL be set.
REQ-022 Auxiliary requesters SHALL hold req and addr until gnt is sampled high; deasserting req before a grant SHALL withdraw the request without side effects.
REQ-023 On an accepted request at edge k, rom_address SHALL load the winner's address at edge k.
REQ-024 The matching valid and data SHALL register rom_q at edge k+ROM_LAT.
REQ-025 Back-to-back acceptance SHALL be supported every cycle, giving full throughput.
REQ-026 A ROM_LAT-deep tag pipeline (NONE/DISP/AUX0/AUX1) SHALL route each return.
REQ-027 In idle cycles, rom_address SHALL hold its value, and a NONE tag SHALL be issued.
REQ-028 disp_data and aux_data SHALL hold their last value when not valid.
REQ-029 For each auxiliary, an 8-bit wait counter SHALL increment each cycle with req=1 and gnt=0, SHALL saturate at STARVE_LIM, and SHALL clear on grant or when req=0.
REQ-030 aux_starve[i] SHALL set when counter i reaches STARVE_LIM and SHALL clear only on reset.
REQ-031 Simultaneous aux0 and aux1 requests with no display request SHALL grant the pointer holder only; the other keeps waiting and counting.

Reset
REQ-032 While reset_n=0 at an edge, the block SHALL clear rom_address, disp_data, aux_data, all valids, aux_starve, wait counters and tags, and SHALL set the pointer to aux0.
REQ-033 Requests in flight at reset SHALL be discarded; no valid SHALL assert for them after reset release.
REQ-034 aux_gnt SHALL be 0 while reset_n=0.

Structure
REQ-035 Package sprite_rom_arb_pkg SHALL hold the tag enum (TAG_NONE, TAG_DISP, TAG_AUX0, TAG_AUX1) and the default ADDR_W, DATA_W and STARVE_LIM constants.
REQ-036 The round-robin picker SHALL be the sub-module sprite_rom_arb_rr (inputs: 2-bit req, pointer; output: one-hot grant).

Verification
REQ-037 Case: disp_req=1, disp_addr=0x00100 for one cycle, ROM_LAT=1 -> rom_address=0x00100 after edge k, and disp_valid=1 with disp_data=ROM[0x00100] at edge k+1 only.
REQ-038 Case: aux_req=2'b11 held with disp_req=0 for 4 cycles -> aux_gnt sequence 01,10,01,10; aux_valid follows by ROM_LAT cycles.
REQ-039 Case: disp_req=1 and aux_req=2'b01 for 300 cycles -> aux_gnt=0 throughout; aux_starve=2'b01 from cycle 255 on; still set after disp_req drops and the grant occurs.
REQ-040 Case: alternating disp/aux0 requests every cycle with ROM_LAT=3 -> every return tagged correctly, with no lost or duplicated valid.
REQ-041 Case: reset_n low for one cycle while two reads are in flight -> no valid for 3 cycles after release; pointer=aux0; all outputs zero.
REQ-042 Case: aux1 raises req, then drops it before a grant while disp_req=1 -> no aux1 valid; wait counter returns to 0.
